dmem_wait_responder: RTL and testbench
======================================

DMEM_WAIT_RESPONDER -- requirements
Module: dmem_wait_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning added wait states per access, legal range 0..15.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning word-address width; storage depth is 2^ADDR_W words of 32 bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_read_ctrl  input  1  read request, held by the initiator until mem_ready.
REQ-006 The block SHALL have port mem_write_ctrl  input  1  write request, held by the initiator until mem_ready.
REQ-007 The block SHALL have port mem_address  input  ADDR_W  word address, i.e. byte address bits [ADDR_W+1:2].
REQ-008 The block SHALL have port mem_byte_en  input  4  write lane enables; bit i covers data bits [8i+7:8i].
REQ-009 The block SHALL have port mem_data_write  input  32  write data.
REQ-010 The block SHALL have port mem_data_read  output  32  read data, registered.
REQ-011 The block SHALL have port mem_ready  output  1  one-cycle completion pulse, registered.
REQ-012 The block SHALL have port mem_busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port mem_error  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-015 IDLE, exactly one of read/write ctrl high at an edge: block SHALL capture address, byte enables, write data and direction, load the wait counter with WAIT_CYCLES, and enter WAIT.
REQ-016 IDLE, read and write ctrl both high: block SHALL perform no access, pulse mem_error for one cycle, and remain in IDLE.
REQ-017 WAIT: counter SHALL decrement each edge; at the edge where it reads 0, the access SHALL be performed and the FSM SHALL enter DONE.
REQ-018 DONE: mem_ready SHALL be high for exactly this one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-019 Latency: a request accepted at edge E0 SHALL see mem_ready high in the cycle after edge E(WAIT_CYCLES+1); WAIT_CYCLES=0 gives ready after E1.
REQ-020 Input changes while in WAIT or DONE SHALL be ignored; the captured request alone SHALL determine the access.
REQ-021 A request still asserted during the DONE cycle SHALL NOT be accepted; the earliest next acceptance SHALL be the edge leaving IDLE one cycle later (minimum period WAIT_CYCLES+3 cycles).
REQ-022 Write: only lanes with mem_byte_en set SHALL be updated; mem_byte_en=0000 SHALL complete normally with no storage change.
REQ-023 Read: mem_data_read SHALL be loaded with the full addressed word at the edge entering DONE, and SHALL hold until the next read completes; writes SHALL NOT alter it.
REQ-024 Address arithmetic SHALL be unsigned, with no wrap or range check, since every ADDR_W value is a valid word.

Reset
REQ-025 rst low SHALL immediately force IDLE, counter 0, mem_ready 0, mem_error 0, mem_busy 0, and mem_data_read 32'h0.
REQ-026 Reset asserted mid-access SHALL abort the access; a write not yet committed SHALL leave storage unchanged.
REQ-027 Storage contents SHALL NOT be reset.

Structure
REQ-028 FSM state encoding and the 32-bit data-width constant SHALL live in a shared package, reused by the pipeline memory stage.
REQ-029 One sub-module is natural: dmem_wait_counter, a loadable down-counter with zero flag; the storage array SHALL be inferred inline.

Verification
REQ-030 Bench SHALL cover: WAIT_CYCLES=2, write 32'hDEADBEEF to address 12'h010 with byte_en 1111, accepted E0 -> mem_ready high after E3 only; mem_busy high from E0 to E3.
REQ-031 Bench SHALL cover: read 12'h010 after that write -> mem_data_read=32'hDEADBEEF coincident with mem_ready; value holds through a later write to 12'h011.
REQ-032 Bench SHALL cover: write 32'h11223344 to 12'h020 with byte_en 0101 over prior 32'hAAAAAAAA -> read returns 32'hAA22AA44.
REQ-033 Bench SHALL cover: read and write ctrl high together in IDLE -> one-cycle mem_error, no mem_ready, storage unchanged.
REQ-034 Bench SHALL cover: rst low one cycle after a write to 12'h030 (old 32'h0) is accepted -> outputs zero at once, FSM IDLE, read of 12'h030 returns 32'h0.
REQ-035 Bench SHALL cover: WAIT_CYCLES=0 with ctrl held continuously -> mem_ready every 3rd cycle, first pulse after E1.

Source files
------------

// File: rtl/dmem_wait_responder_pkg.sv
// Shared types for the data-memory responder and the pipeline memory stage.
// Holds FSM encoding, data width and the byte-lane merge helper.
package dmem_wait_responder_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Replace only the lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// Request/response bus between a memory initiator and the responder.
// master: drives ctrl/address/data; slave: returns read data and status.
interface dmem_wait_responder_if #(
  parameter int ADDR_W = 12
);
  import dmem_wait_responder_pkg::*;

  logic              mem_read_ctrl;
  logic              mem_write_ctrl;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byte_en;
  logic [DATA_W-1:0] mem_data_write;
  logic [DATA_W-1:0] mem_data_read;
  logic              mem_ready;
  logic              mem_busy;
  logic              mem_error;

  modport master (
    output mem_read_ctrl,
    output mem_write_ctrl,
    output mem_address,
    output mem_byte_en,
    output mem_data_write,
    input  mem_data_read,
    input  mem_ready,
    input  mem_busy,
    input  mem_error
  );

  modport slave (
    input  mem_read_ctrl,
    input  mem_write_ctrl,
    input  mem_address,
    input  mem_byte_en,
    input  mem_data_write,
    output mem_data_read,
    output mem_ready,
    output mem_busy,
    output mem_error
  );

endinterface

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter with zero flag for access wait states.
// Ports: clk_i, rst_ni, load_i/load_val_i, dec_i, cnt_o, zero_o.
module dmem_wait_counter
  import dmem_wait_responder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_wait_responder.sv
// Word-addressed data memory answering each access after WAIT_CYCLES waits.
// Ports: clk, rst (async, active-low), bus (slave side of the memory bus).
module dmem_wait_responder
  import dmem_wait_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 12
) (
  input  logic clk,
  input  logic rst,
  dmem_wait_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              error_q;

  // Not reset: contents survive rst.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             req_one;
  logic             req_both;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             commit;

  assign req_one  = bus.mem_read_ctrl ^ bus.mem_write_ctrl;
  assign req_both = bus.mem_read_ctrl & bus.mem_write_ctrl;
  assign cnt_load = (state_q == IDLE) && req_one;
  assign cnt_dec  = (state_q == WAIT);
  // The access happens on the WAIT edge where the counter already reads 0.
  assign commit   = (state_q == WAIT) && cnt_zero;

  dmem_wait_counter u_cnt (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(WAIT_CYCLES)),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_one) begin
            addr_q  <= bus.mem_address;
            be_q    <= bus.mem_byte_en;
            wdata_q <= bus.mem_data_write;
            wr_q    <= bus.mem_write_ctrl;
            state_q <= WAIT;
          end else if (req_both) begin
            error_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_zero) begin
            if (!wr_q) rdata_q <= mem_q[addr_q];
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_q)
      mem_q[addr_q] <= merge_bytes(mem_q[addr_q], wdata_q, be_q);
  end

  assign bus.mem_data_read = rdata_q;
  assign bus.mem_ready     = ready_q;
  assign bus.mem_busy      = (state_q != IDLE);
  assign bus.mem_error     = error_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0).
// Checks latency, byte lanes, error, reset abort and back-to-back cadence.
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  dmem_wait_responder_if #(.ADDR_W(12)) a_if ();
  dmem_wait_responder_if #(.ADDR_W(12)) b_if ();

  dmem_wait_responder #(.WAIT_CYCLES(2), .ADDR_W(12)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if)
  );

  dmem_wait_responder #(.WAIT_CYCLES(0), .ADDR_W(12)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    a_if.mem_read_ctrl  = rd;
    a_if.mem_write_ctrl = wr;
    a_if.mem_address    = addr;
    a_if.mem_byte_en    = be;
    a_if.mem_data_write = wd;
  endtask

  // Hold the request until mem_ready (bounded), then release and let
  // the FSM leave DONE.
  task automatic acc_a(input logic rd, input logic wr,
                       input logic [11:0] addr, input logic [3:0] be,
                       input logic [31:0] wd,
                       output int lat, output logic [31:0] rdat);
    drv_a(rd, wr, addr, be, wd);
    lat  = 0;
    rdat = 'x;
    while (lat < 20) begin
      tick();
      lat++;
      if (a_if.mem_ready === 1'b1) break;
    end
    rdat = a_if.mem_data_read;
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();
  endtask

  int          lat;
  logic [31:0] rd;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    b_if.mem_read_ctrl  = 1'b0;
    b_if.mem_write_ctrl = 1'b0;
    b_if.mem_address    = 12'h005;
    b_if.mem_byte_en    = 4'hF;
    b_if.mem_data_write = 32'h0000_0001;
    tick();
    tick();
    chk("rst_ready", 32'(a_if.mem_ready), 32'h0);
    chk("rst_busy",  32'(a_if.mem_busy),  32'h0);
    chk("rst_error", 32'(a_if.mem_error), 32'h0);
    chk("rst_rdata", a_if.mem_data_read,  32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // Write DEADBEEF @010, latency traced edge by edge.
    drv_a(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF);
    tick();
    chk("wr_e0_busy",  32'(a_if.mem_busy),  32'h1);
    chk("wr_e0_ready", 32'(a_if.mem_ready), 32'h0);
    tick();
    chk("wr_e1_ready", 32'(a_if.mem_ready), 32'h0);
    tick();
    chk("wr_e2_ready", 32'(a_if.mem_ready), 32'h0);
    chk("wr_e2_busy",  32'(a_if.mem_busy),  32'h1);
    tick();
    chk("wr_e3_ready", 32'(a_if.mem_ready), 32'h1);
    chk("wr_e3_busy",  32'(a_if.mem_busy),  32'h1);
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();
    chk("wr_e4_ready", 32'(a_if.mem_ready), 32'h0);
    chk("wr_e4_busy",  32'(a_if.mem_busy),  32'h0);

    acc_a(1'b1, 1'b0, 12'h010, 4'h0, 32'h0, lat, rd);
    chk("rd010_lat",  32'(lat), 32'd4);
    chk("rd010_data", rd, 32'hDEAD_BEEF);

    acc_a(1'b0, 1'b1, 12'h011, 4'hF, 32'h1234_5678, lat, rd);
    chk("wr011_lat",  32'(lat), 32'd4);
    chk("rdata_hold", a_if.mem_data_read, 32'hDEAD_BEEF);

    acc_a(1'b1, 1'b0, 12'h011, 4'h0, 32'h0, lat, rd);
    chk("rd011_data", rd, 32'h1234_5678);

    // Partial lane write.
    acc_a(1'b0, 1'b1, 12'h020, 4'hF, 32'hAAAA_AAAA, lat, rd);
    acc_a(1'b0, 1'b1, 12'h020, 4'b0101, 32'h1122_3344, lat, rd);
    acc_a(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, lat, rd);
    chk("be0101_data", rd, 32'hAA22_AA44);

    // All lanes off: completes, nothing stored.
    acc_a(1'b0, 1'b1, 12'h020, 4'h0, 32'hFFFF_FFFF, lat, rd);
    chk("be0000_lat", 32'(lat), 32'd4);
    acc_a(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, lat, rd);
    chk("be0000_data", rd, 32'hAA22_AA44);

    // Inputs changed during WAIT are ignored.
    drv_a(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    tick();
    drv_a(1'b0, 1'b1, 12'h020, 4'hF, 32'h0);
    tick();
    tick();
    tick();
    chk("ign_ready", 32'(a_if.mem_ready), 32'h1);
    chk("ign_data",  a_if.mem_data_read,  32'hDEAD_BEEF);
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();
    acc_a(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, lat, rd);
    chk("ign_store", rd, 32'hAA22_AA44);

    // Read and write together: error only.
    drv_a(1'b1, 1'b1, 12'h020, 4'hF, 32'h0);
    tick();
    chk("both_error", 32'(a_if.mem_error), 32'h1);
    chk("both_ready", 32'(a_if.mem_ready), 32'h0);
    chk("both_busy",  32'(a_if.mem_busy),  32'h0);
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();
    chk("both_err_clr", 32'(a_if.mem_error), 32'h0);
    acc_a(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, lat, rd);
    chk("both_store", rd, 32'hAA22_AA44);

    // Reset aborts an accepted write.
    acc_a(1'b0, 1'b1, 12'h030, 4'hF, 32'h0, lat, rd);
    acc_a(1'b1, 1'b0, 12'h010, 4'h0, 32'h0, lat, rd);
    drv_a(1'b0, 1'b1, 12'h030, 4'hF, 32'h5555_5555);
    tick();
    tick();
    rst_a = 1'b0;
    #1;
    chk("abort_busy",  32'(a_if.mem_busy),  32'h0);
    chk("abort_ready", 32'(a_if.mem_ready), 32'h0);
    chk("abort_error", 32'(a_if.mem_error), 32'h0);
    chk("abort_rdata", a_if.mem_data_read,  32'h0);
    drv_a(1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();
    rst_a = 1'b1;
    tick();
    acc_a(1'b1, 1'b0, 12'h030, 4'h0, 32'h0, lat, rd);
    chk("abort_lat",   32'(lat), 32'd4);
    chk("abort_store", rd, 32'h0);

    // Zero wait states, request held: ready every third cycle.
    b_if.mem_write_ctrl = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk($sformatf("w0_ready_e%0d", k), 32'(b_if.mem_ready),
          (k % 3 == 1) ? 32'h1 : 32'h0);
    end
    b_if.mem_write_ctrl = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
